// File: rtl/serial_mouse_encoder.sv
// rtl/serial_mouse_encoder.sv - Microsoft serial mouse packet encoder with RTS ident byte
module serial_mouse_encoder #(
  parameter int          ACC_WIDTH  = 10,
  parameter int          GAP_CYCLES = 250000,
  parameter logic [7:0]  ID_BYTE    = 8'h4D
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iDx,
  input  logic [7:0] iDy,
  input  logic       iMove,
  input  logic       iBtnL,
  input  logic       iBtnR,
  input  logic       iRts,
  output logic [7:0] oData,
  output logic       oValid,
  input  logic       iReady
);

  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int EW = ACC_WIDTH + 2;

  localparam logic signed [EW-1:0]        ACC_MAX  = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0]        ACC_MIN  = {3'b111, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] BYTE_MAX = ACC_WIDTH'(127);
  localparam logic signed [ACC_WIDTH-1:0] BYTE_MIN = ACC_WIDTH'(-128);
  localparam logic [GW-1:0]               GAP_LOAD = GW'(GAP_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_ID, S_B0, S_B1, S_B2} state_t;

  state_t                       state_q;
  logic [7:0]                   data_q, b1_q, b2_q;
  logic                         valid_q;
  logic signed [ACC_WIDTH-1:0]  acc_x_q, acc_y_q, acc_x_d, acc_y_d;
  logic                         last_l_q, last_r_q, rts_dly_q;
  logic [GW-1:0]                gap_q;

  logic [7:0]                   sx, sy;
  logic signed [EW-1:0]         sum_x, sum_y;
  logic                         powered, snap, xfer;

  // Clamp an accumulator to the signed byte range carried in a packet.
  function automatic logic [7:0] clamp8(input logic signed [ACC_WIDTH-1:0] a);
    if (a > BYTE_MAX)      return 8'h7F;
    else if (a < BYTE_MIN) return 8'h80;
    else                   return a[7:0];
  endfunction

  // Saturate the widened update back into the accumulator range.
  function automatic logic signed [ACC_WIDTH-1:0] sat(input logic signed [EW-1:0] v);
    if (v > ACC_MAX)      return ACC_MAX[ACC_WIDTH-1:0];
    else if (v < ACC_MIN) return ACC_MIN[ACC_WIDTH-1:0];
    else                  return v[ACC_WIDTH-1:0];
  endfunction

  assign powered = iRts & rts_dly_q;
  assign xfer    = valid_q & iReady;
  assign snap    = powered && (state_q == S_IDLE) && (gap_q == '0) &&
                   ((acc_x_q != '0) || (acc_y_q != '0) ||
                    (iBtnL != last_l_q) || (iBtnR != last_r_q));
  assign oData   = data_q;
  assign oValid  = valid_q;

  // Accumulator next state: remove what the snapshot sends, add new motion, saturate.
  always_comb begin
    sx      = clamp8(acc_x_q);
    sy      = clamp8(acc_y_q);
    sum_x   = {{2{acc_x_q[ACC_WIDTH-1]}}, acc_x_q}
            - (snap  ? {{(EW-8){sx[7]}}, sx}   : '0)
            + (iMove ? {{(EW-8){iDx[7]}}, iDx} : '0);
    sum_y   = {{2{acc_y_q[ACC_WIDTH-1]}}, acc_y_q}
            - (snap  ? {{(EW-8){sy[7]}}, sy}   : '0)
            + (iMove ? {{(EW-8){iDy[7]}}, iDy} : '0);
    acc_x_d = sat(sum_x);
    acc_y_d = sat(sum_y);
  end

  // Protocol FSM, handshake registers, gap timer and RTS tracking.
  always_ff @(posedge iClk) begin
    rts_dly_q <= iRts;
    if (iRst || !iRts) begin
      if (iRst) rts_dly_q <= 1'b0;
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
      b1_q     <= 8'h00;
      b2_q     <= 8'h00;
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      last_l_q <= 1'b0;
      last_r_q <= 1'b0;
      gap_q    <= '0;
    end else if (!rts_dly_q) begin
      // Mouse just powered up: drop anything in flight and identify.
      state_q <= S_ID;
      valid_q <= 1'b1;
      data_q  <= ID_BYTE;
      acc_x_q <= '0;
      acc_y_q <= '0;
      gap_q   <= '0;
    end else begin
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      if (gap_q != '0) gap_q <= gap_q - 1'b1;
      case (state_q)
        S_IDLE: if (snap) begin
          state_q  <= S_B0;
          valid_q  <= 1'b1;
          data_q   <= {1'b0, 1'b1, iBtnL, iBtnR, sy[7:6], sx[7:6]};
          b1_q     <= {2'b00, sx[5:0]};
          b2_q     <= {2'b00, sy[5:0]};
          last_l_q <= iBtnL;
          last_r_q <= iBtnR;
        end
        S_ID: if (xfer) begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
        S_B0: if (xfer) begin
          state_q <= S_B1;
          data_q  <= b1_q;
        end
        S_B1: if (xfer) begin
          state_q <= S_B2;
          data_q  <= b2_q;
        end
        S_B2: if (xfer) begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          gap_q   <= GAP_LOAD;
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
